// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: FSM states, ExcCodes,
// CP0 Status bit positions and the cause-word packing helper.
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXC      = 3'd1,
        EXC_JMP  = 3'd2,
        ERET     = 3'd3,
        ERET_JMP = 3'd4
    } state_t;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BRK = 5'd9;
    localparam logic [4:0] EXC_TEQ = 5'd13;

    localparam int ST_IE  = 0;
    localparam int ST_SYS = 1;
    localparam int ST_BRK = 2;
    localparam int ST_TEQ = 3;
    localparam int ST_INT = 4;

    localparam int CAUSE_IP = 10;

    // Cause word: ExcCode in [6:2], pending-interrupt flag in the IP bit.
    function automatic logic [31:0] make_cause(input logic ip, input logic [4:0] code);
        logic [31:0] c;
        c           = 32'd0;
        c[6:2]      = code;
        c[CAUSE_IP] = ip;
        return c;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Decode/CP0/PC-mux side bundle of the exception sequencer.
// master = the sequencer, slave = the pipeline/CP0 environment driving it.
interface exc_ctrl_if;
    logic        instr_valid;
    logic [31:0] pc;
    logic        syscall_i;
    logic        break_i;
    logic        teq_i;
    logic        eret_i;
    logic        ext_int;
    logic [31:0] status;
    logic [31:0] epc;

    logic        exception;
    logic [31:0] cause;
    logic [31:0] exc_pc;
    logic        eret;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;

    modport master (
        input  instr_valid, pc, syscall_i, break_i, teq_i, eret_i, ext_int, status, epc,
        output exception, cause, exc_pc, eret, redirect, redirect_pc, stall
    );

    modport slave (
        output instr_valid, pc, syscall_i, break_i, teq_i, eret_i, ext_int, status, epc,
        input  exception, cause, exc_pc, eret, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/int_latch.sv
// External interrupt latch: rising-edge detector feeding a sticky pending flag.
// A new edge wins over a coincident clear so a back-to-back interrupt is not lost.
module int_latch (
    input  logic clk,
    input  logic rst,
    input  logic ext_int,
    input  logic clr,
    output logic pend
);

    logic ext_int_q_r;
    logic pend_r;

    // Edge history and sticky pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_int_q_r <= 1'b0;
            pend_r      <= 1'b0;
        end else begin
            ext_int_q_r <= ext_int;
            if (ext_int & ~ext_int_q_r) begin
                pend_r <= 1'b1;
            end else if (clr) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

    assign pend = pend_r;

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: picks the highest-priority enabled trap, eret or interrupt
// in IDLE, then strobes CP0 and redirects fetch over two stalled cycles.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    exc_ctrl_if.master  bus
);

    state_t      state_r;
    logic        exception_r;
    logic [31:0] cause_r;
    logic [31:0] exc_pc_r;
    logic        eret_r;
    logic        redirect_r;
    logic [31:0] redirect_pc_r;

    logic        int_pend_s;
    logic        take_exc_s;
    logic        take_eret_s;
    logic        take_int_s;
    logic [4:0]  code_s;
    logic        ie_s;
    logic        unused_status_s;

    assign ie_s            = bus.status[ST_IE];
    assign unused_status_s = ^bus.status[31:5];

    int_latch u_int_latch (
        .clk     (clk),
        .rst     (rst),
        .ext_int (bus.ext_int),
        .clr     (take_int_s),
        .pend    (int_pend_s)
    );

    // Priority selection; masked traps simply fall through to the next source.
    always_comb begin
        take_exc_s  = 1'b0;
        take_eret_s = 1'b0;
        take_int_s  = 1'b0;
        code_s      = EXC_INT;
        if ((state_r == IDLE) && bus.instr_valid) begin
            if (bus.syscall_i && ie_s && bus.status[ST_SYS]) begin
                take_exc_s = 1'b1;
                code_s     = EXC_SYS;
            end else if (bus.break_i && ie_s && bus.status[ST_BRK]) begin
                take_exc_s = 1'b1;
                code_s     = EXC_BRK;
            end else if (bus.teq_i && ie_s && bus.status[ST_TEQ]) begin
                take_exc_s = 1'b1;
                code_s     = EXC_TEQ;
            end else if (bus.eret_i) begin
                take_eret_s = 1'b1;
            end else if (int_pend_s && ie_s && bus.status[ST_INT]) begin
                take_exc_s = 1'b1;
                take_int_s = 1'b1;
                code_s     = EXC_INT;
            end else begin
                take_exc_s = 1'b0;
            end
        end else begin
            take_exc_s = 1'b0;
        end
    end

    // Sequencer state and registered CP0 / PC-mux outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            exception_r   <= 1'b0;
            cause_r       <= 32'd0;
            exc_pc_r      <= 32'd0;
            eret_r        <= 1'b0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_exc_s) begin
                        state_r     <= EXC;
                        exception_r <= 1'b1;
                        cause_r     <= make_cause(int_pend_s, code_s);
                        exc_pc_r    <= bus.pc;
                    end else if (take_eret_s) begin
                        state_r <= ERET;
                        eret_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXC: begin
                    state_r       <= EXC_JMP;
                    exception_r   <= 1'b0;
                    redirect_r    <= 1'b1;
                    redirect_pc_r <= EXC_VECTOR;
                end
                ERET: begin
                    // EPC is stable here: the eret strobe only restores Status.
                    state_r       <= ERET_JMP;
                    eret_r        <= 1'b0;
                    redirect_r    <= 1'b1;
                    redirect_pc_r <= bus.epc;
                end
                EXC_JMP, ERET_JMP: begin
                    state_r       <= IDLE;
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= 32'd0;
                end
                default: begin
                    state_r       <= IDLE;
                    exception_r   <= 1'b0;
                    eret_r        <= 1'b0;
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= 32'd0;
                end
            endcase
        end
    end

    assign bus.exception   = exception_r;
    assign bus.cause       = cause_r;
    assign bus.exc_pc      = exc_pc_r;
    assign bus.eret        = eret_r;
    assign bus.redirect    = redirect_r;
    assign bus.redirect_pc = redirect_pc_r;
    assign bus.stall       = (state_r != IDLE);

endmodule
